// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, one radix-2 step per cycle.
// Operands are reduced to magnitudes on start; signs are reapplied in the FIX state.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hilo_wen,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state, state_nx;
    logic                 op_div;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     a_r;
    logic                 neg_q, neg_r, dz;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     q_fix, r_fix;

    always_comb begin
        a_neg     = ~op[0] & a[WIDTH-1];
        b_neg     = ~op[0] & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        // Multiply: low half of acc holds the multiplier, upper half accumulates
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
        // Divide: low half of acc shifts the dividend out and the quotient in
        div_shift = {rem, acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, mcand};
        prod_fix  = neg_q ? -acc : acc;
        q_fix     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix     = neg_r ? -rem : rem;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        case (state)
            IDLE: if (start && !flush) state_nx = CALC;
            CALC: begin
                if (flush)                     state_nx = IDLE;
                else if (cnt == CNT_W'(1))     state_nx = FIX;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            op_div   <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            rem      <= '0;
            a_r      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (hilo_wen) begin
                        if (hilo_sel) hi <= hilo_wdata;
                        else          lo <= hilo_wdata;
                    end
                    if (start && !flush) begin
                        op_div <= op[1];
                        cnt    <= CNT_W'(WIDTH);
                        acc    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        mcand  <= op[1] ? b_mag : a_mag;
                        rem    <= '0;
                        a_r    <= a;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dz     <= op[1] && (b == '0);
                    end
                end
                CALC: begin
                    if (flush) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (op_div) begin
                            if (!div_trial[WIDTH]) begin
                                rem <= div_trial[WIDTH-1:0];
                                acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
                            end else begin
                                rem <= div_shift[WIDTH-1:0];
                                acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        done     <= 1'b1;
                        div_zero <= dz;
                        if (!op_div) begin
                            {hi, lo} <= prod_fix;
                        end else if (dz) begin
                            lo <= '1;
                            hi <= a_r;
                        end else begin
                            lo <= q_fix;
                            hi <= r_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a WIDTH=32 instance plus a WIDTH=16 instance.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, flush, hilo_wen, hilo_sel;
    logic [1:0]  op;
    logic [31:0] a, b, hilo_wdata, hi, lo;
    logic        busy, done, div_zero;

    logic        start16, flush16, hilo_wen16, hilo_sel16;
    logic [1:0]  op16;
    logic [15:0] a16, b16, hilo_wdata16, hi16, lo16;
    logic        busy16, done16, div_zero16;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hilo_wen(hilo_wen), .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .a(a16), .b(b16),
        .flush(flush16), .hilo_wen(hilo_wen16), .hilo_sel(hilo_sel16), .hilo_wdata(hilo_wdata16),
        .busy(busy16), .done(done16), .div_zero(div_zero16), .hi(hi16), .lo(lo16)
    );

    // Launches one op on the 32-bit unit from a cycle where it is idle and
    // waits (bounded) for done; lat counts edges after the accepting edge.
    task automatic do_op32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           output int lat, output int bcyc, output logic dzs);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcyc = 0; dzs = 1'b0;
        while (lat < 100) begin
            if (busy) bcyc++;
            if (done) begin
                dzs = div_zero;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (hi !== 32'h0)  begin miscompares++; $display("FAIL reset_hi got %h want 0", hi); end
        vectors++; if (lo !== 32'h0)  begin miscompares++; $display("FAIL reset_lo got %h want 0", lo); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dz got %b want 0", div_zero); end
        vectors++; if (hi16 !== 16'h0 || lo16 !== 16'h0 || busy16 !== 1'b0)
            begin miscompares++; $display("FAIL reset_w16 got %h/%h/%b want 0/0/0", hi16, lo16, busy16); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_multu;
        int lat, bc; logic dzs;
        do_op32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, dzs);
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL multu_latency got %0d want 33", lat); end
        vectors++; if (bc !== 33)  begin miscompares++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
        vectors++; if (hi !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_hi got %h want fffffffe", hi); end
        vectors++; if (lo !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_lo got %h want 00000001", lo); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL multu_busy_at_done got %b want 0", busy); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL multu_done_pulse got %b want 0", done); end
    endtask

    task automatic test_signed;
        int lat, bc; logic dzs;
        do_op32(2'b00, -32'sd3, 32'd5, lat, bc, dzs);
        vectors++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1)
            begin miscompares++; $display("FAIL mult_neg got %h_%h want ffffffff_fffffff1", hi, lo); end
        do_op32(2'b10, -32'sd7, 32'd2, lat, bc, dzs);
        vectors++; if (lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_neg_q got %h want fffffffd", lo); end
        vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_neg_r got %h want ffffffff", hi); end
        do_op32(2'b10, 32'd7, -32'sd2, lat, bc, dzs);
        vectors++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFD})
            begin miscompares++; $display("FAIL div_negdivisor got %h_%h want 00000001_fffffffd", hi, lo); end
        do_op32(2'b11, 32'd7, 32'd2, lat, bc, dzs);
        vectors++; if (lo !== 32'd3) begin miscompares++; $display("FAIL divu_q got %h want 3", lo); end
        vectors++; if (hi !== 32'd1) begin miscompares++; $display("FAIL divu_r got %h want 1", hi); end
        vectors++; if (lat !== 33)   begin miscompares++; $display("FAIL divu_latency got %0d want 33", lat); end
    endtask

    task automatic test_div_zero;
        int lat, bc; logic dzs;
        do_op32(2'b11, 32'h1234, 32'h0, lat, bc, dzs);
        vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL dz_lo got %h want ffffffff", lo); end
        vectors++; if (hi !== 32'h1234) begin miscompares++; $display("FAIL dz_hi got %h want 1234", hi); end
        vectors++; if (dzs !== 1'b1) begin miscompares++; $display("FAIL dz_flag got %b want 1", dzs); end
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL dz_latency got %0d want 33", lat); end
        do_op32(2'b10, -32'sd9, 32'h0, lat, bc, dzs);
        vectors++; if ({hi, lo, dzs} !== {32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1})
            begin miscompares++; $display("FAIL dz_signed got %h_%h_%b want fffffff7_ffffffff_1", hi, lo, dzs); end
        do_op32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dzs);
        vectors++; if (lo !== 32'h8000_0000) begin miscompares++; $display("FAIL ovf_lo got %h want 80000000", lo); end
        vectors++; if (hi !== 32'h0) begin miscompares++; $display("FAIL ovf_hi got %h want 0", hi); end
        vectors++; if (dzs !== 1'b0) begin miscompares++; $display("FAIL ovf_flag got %b want 0", dzs); end
    endtask

    task automatic test_flush;
        int dones = 0;
        hilo_wen = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'hAA;
        @(posedge clk); #1;
        hilo_wen = 1'b0;
        vectors++; if (lo !== 32'hAA) begin miscompares++; $display("FAIL mtlo got %h want aa", lo); end
        op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy got %b want 0", busy); end
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        vectors++; if (dones !== 0) begin miscompares++; $display("FAIL flush_no_done got %0d pulses want 0", dones); end
        vectors++; if (lo !== 32'hAA) begin miscompares++; $display("FAIL flush_lo got %h want aa", lo); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++; if (busy !== 1'b0 || lo !== 32'hAA)
            begin miscompares++; $display("FAIL flush_idle got busy=%b lo=%h want 0/aa", busy, lo); end
    endtask

    task automatic test_start_while_busy;
        int lat = 0;
        int busy_after = 0;
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 6;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL swb_latency got %0d want 33", lat); end
        vectors++; if ({hi, lo} !== {32'd2, 32'd14})
            begin miscompares++; $display("FAIL swb_result got %h_%h want 00000002_0000000e", hi, lo); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (busy) busy_after++;
        end
        vectors++; if (busy_after !== 0) begin miscompares++; $display("FAIL swb_no_queue got %0d busy cycles want 0", busy_after); end
    endtask

    task automatic test_back_to_back;
        int lat, bc; logic dzs;
        do_op32(2'b11, 32'd7, 32'd2, lat, bc, dzs);
        do_op32(2'b01, 32'd6, 32'd7, lat, bc, dzs);
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL b2b_latency got %0d want 33", lat); end
        vectors++; if ({hi, lo} !== {32'd0, 32'd42})
            begin miscompares++; $display("FAIL b2b_result got %h_%h want 00000000_0000002a", hi, lo); end
        op = 2'b11; a = 32'd50; b = 32'd8; start = 1'b1;
        hilo_wen = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h55;
        @(posedge clk); #1;
        start = 1'b0; hilo_wen = 1'b0;
        vectors++; if (lo !== 32'h55 || busy !== 1'b1)
            begin miscompares++; $display("FAIL same_edge_mtlo got lo=%h busy=%b want 55/1", lo, busy); end
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++; if ({hi, lo} !== {32'd2, 32'd6})
            begin miscompares++; $display("FAIL same_edge_result got %h_%h want 00000002_00000006", hi, lo); end
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        op = 2'b00; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        vectors++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0)
            begin miscompares++; $display("FAIL rst_mid got hi=%h lo=%h busy=%b want 0/0/0", hi, lo, busy); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        vectors++; if (dones !== 0) begin miscompares++; $display("FAIL rst_mid_no_done got %0d pulses want 0", dones); end
    endtask

    task automatic test_w16;
        int lat = 1;
        op16 = 2'b01; a16 = 16'hFFFF; b16 = 16'h0002; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        hilo_wen16 = 1'b1; hilo_sel16 = 1'b1; hilo_wdata16 = 16'hBEEF;
        @(posedge clk); #1;
        hilo_wen16 = 1'b0;
        vectors++; if (hi16 !== 16'h0 || lo16 !== 16'h0)
            begin miscompares++; $display("FAIL w16_mthi_busy got %h/%h want 0000/0000", hi16, lo16); end
        while (!done16 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++; if (lat !== 17) begin miscompares++; $display("FAIL w16_latency got %0d want 17", lat); end
        vectors++; if (hi16 !== 16'h0001) begin miscompares++; $display("FAIL w16_hi got %h want 0001", hi16); end
        vectors++; if (lo16 !== 16'hFFFE) begin miscompares++; $display("FAIL w16_lo got %h want fffe", lo16); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; hilo_wen = 1'b0; hilo_sel = 1'b0;
        op = '0; a = '0; b = '0; hilo_wdata = '0;
        start16 = 1'b0; flush16 = 1'b0; hilo_wen16 = 1'b0; hilo_sel16 = 1'b0;
        op16 = '0; a16 = '0; b16 = '0; hilo_wdata16 = '0;
        @(posedge clk); #1;
        test_reset;
        test_multu;
        test_signed;
        test_div_zero;
        test_flush;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid;
        test_w16;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
